exhaustive_stim_ctrl: RTL and testbench



---
 rtl/exhaustive_stim_ctrl.sv | 134 +++++++++++++
 tb/tb_exhaustive_stim_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/exhaustive_stim_ctrl.sv
// Exhaustive stimulus sequencer: sweeps stim_out through all 2^IN_W
// patterns, holding each SETTLE cycles, then captures resp_in.
// Ports: clk, rst (sync, active-high), start, abort, busy, done,
//   stim_out/stim_valid (to datapath), resp_in (from datapath),
//   cap_valid/cap_index/cap_data (capture stream), sig_out.
// Option: define EXHAUSTIVE_STIM_CTRL_SIGNATURE_EN for a rotate-XOR
//   response signature on sig_out; otherwise sig_out is tied to 0.
module exhaustive_stim_ctrl #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 2,
  parameter int SETTLE = 1,
  parameter int SIG_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [IN_W-1:0]  stim_out,
  output logic             stim_valid,
  input  logic [OUT_W-1:0] resp_in,
  output logic             cap_valid,
  output logic [IN_W-1:0]  cap_index,
  output logic [OUT_W-1:0] cap_data,
  output logic [SIG_W-1:0] sig_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]      SETTLE_C = 8'(SETTLE);
  localparam logic [IN_W-1:0] ALL_ONES = {IN_W{1'b1}};

  state_t     state, state_n;
  logic [7:0] settle_cnt;
  logic       cap;
  logic       last;

  always_comb begin
    state_n = state;
    cap     = 1'b0;
    last    = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = RUN;
      RUN: begin
        // abort takes priority over a capture on the same edge
        if (abort) begin
          state_n = IDLE;
        end else if (settle_cnt == SETTLE_C) begin
          cap = 1'b1;
          if (stim_out == ALL_ONES) begin
            last    = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      stim_out   <= '0;
      stim_valid <= 1'b0;
      settle_cnt <= 8'd0;
      cap_valid  <= 1'b0;
      cap_index  <= '0;
      cap_data   <= '0;
    end else begin
      state     <= state_n;
      cap_valid <= cap;
      if (cap) begin
        cap_index <= stim_out;
        cap_data  <= resp_in;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            stim_out   <= '0;
            stim_valid <= 1'b1;
            settle_cnt <= 8'd1;
          end
        end
        RUN: begin
          if (abort || last) begin
            stim_out   <= '0;
            stim_valid <= 1'b0;
          end else if (cap) begin
            stim_out   <= stim_out + 1'b1;
            settle_cnt <= 8'd1;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        DONE: begin
          stim_out   <= '0;
          stim_valid <= 1'b0;
        end
        default: begin
          stim_out   <= '0;
          stim_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

`ifdef EXHAUSTIVE_STIM_CTRL_SIGNATURE_EN
  logic [SIG_W-1:0] sig;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (state == IDLE && start) begin
      sig <= '0;
    end else if (cap) begin
      sig <= {sig[SIG_W-2:0], sig[SIG_W-1]} ^ SIG_W'(resp_in);
    end
  end

  assign sig_out = sig;
`else
  assign sig_out = '0;
`endif

endmodule

// File: tb/tb_exhaustive_stim_ctrl.sv
// Directed bench for exhaustive_stim_ctrl: three instances cover
// SETTLE=1 loopback, SETTLE=3 loopback/abort, and IN_W=1 inverted.
module tb_exhaustive_stim_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;

`ifdef EXHAUSTIVE_STIM_CTRL_SIGNATURE_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  // Instance a: IN_W=2, SETTLE=1, loopback
  logic        start_a = 0, abort_a = 0;
  logic        busy_a, done_a, sv_a, cv_a;
  logic [1:0]  stim_a, ci_a, cd_a;
  logic [15:0] sig_a;

  exhaustive_stim_ctrl #(.IN_W(2), .OUT_W(2), .SETTLE(1), .SIG_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .stim_out(stim_a),
    .stim_valid(sv_a), .resp_in(stim_a), .cap_valid(cv_a),
    .cap_index(ci_a), .cap_data(cd_a), .sig_out(sig_a)
  );

  // Instance b: IN_W=2, SETTLE=3, loopback
  logic        start_b = 0, abort_b = 0;
  logic        busy_b, done_b, sv_b, cv_b;
  logic [1:0]  stim_b, ci_b, cd_b;
  logic [15:0] sig_b;

  exhaustive_stim_ctrl #(.IN_W(2), .OUT_W(2), .SETTLE(3), .SIG_W(16)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .stim_out(stim_b),
    .stim_valid(sv_b), .resp_in(stim_b), .cap_valid(cv_b),
    .cap_index(ci_b), .cap_data(cd_b), .sig_out(sig_b)
  );

  // Instance c: IN_W=1, OUT_W=1, inverted response
  logic        start_c = 0, abort_c = 0;
  logic        busy_c, done_c, sv_c, cv_c;
  logic [0:0]  stim_c, ci_c, cd_c, resp_c;
  logic [15:0] sig_c;

  assign resp_c = ~stim_c;

  exhaustive_stim_ctrl #(.IN_W(1), .OUT_W(1), .SETTLE(1), .SIG_W(16)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort_c),
    .busy(busy_c), .done(done_c), .stim_out(stim_c),
    .stim_valid(sv_c), .resp_in(resp_c), .cap_valid(cv_c),
    .cap_index(ci_c), .cap_data(cd_c), .sig_out(sig_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge, then sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int caps;
    bit bad;

    rst = 1'b1;
    step();
    step();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_stim", stim_a, 0);
    chk("rst_sv", sv_a, 0);
    chk("rst_cv", cv_a, 0);
    chk("rst_ci", ci_a, 0);
    chk("rst_cd", cd_a, 0);
    chk("rst_sig", sig_a, 0);
    rst = 1'b0;
    step();

    // SETTLE=1 loopback sweep
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("a0_busy", busy_a, 1);
    chk("a0_stim", stim_a, 0);
    chk("a0_sv", sv_a, 1);
    chk("a0_cv", cv_a, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("a_stim", stim_a, i);
      chk("a_cv", cv_a, 1);
      chk("a_ci", ci_a, i - 1);
      chk("a_cd", cd_a, i - 1);
      chk("a_done_lo", done_a, 0);
      chk("a_busy_hi", busy_a, 1);
    end
    step();
    chk("a4_done", done_a, 1);
    chk("a4_busy", busy_a, 0);
    chk("a4_cv", cv_a, 1);
    chk("a4_ci", ci_a, 3);
    chk("a4_cd", cd_a, 3);
    chk("a4_sv", sv_a, 0);
    chk("a4_stim", stim_a, 0);
    chk("a4_sig", sig_a, SIG_ON ? 32'h3 : 32'h0);
    step();
    chk("a5_done", done_a, 0);
    chk("a5_cv", cv_a, 0);
    chk("a5_ci_hold", ci_a, 3);
    chk("a5_sig_hold", sig_a, SIG_ON ? 32'h3 : 32'h0);

    // start held high across two sweeps
    start_a = 1'b1;
    step();
    chk("h_busy", busy_a, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("h_stim", stim_a, i);
      chk("h_busy_run", busy_a, 1);
    end
    step();
    chk("h_done", done_a, 1);
    step();
    chk("h_idle_busy", busy_a, 0);
    chk("h_idle_done", done_a, 0);
    step();
    chk("h_rerun_busy", busy_a, 1);
    chk("h_rerun_stim", stim_a, 0);
    chk("h_rerun_sig", sig_a, 0);
    start_a = 1'b0;
    step();
    step();
    chk("r_pre_stim", stim_a, 2);

    // reset mid-sweep
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_busy", busy_a, 0);
    chk("r_done", done_a, 0);
    chk("r_stim", stim_a, 0);
    chk("r_sv", sv_a, 0);
    chk("r_cv", cv_a, 0);
    chk("r_ci", ci_a, 0);
    chk("r_cd", cd_a, 0);
    chk("r_sig", sig_a, 0);
    step();
    chk("r_stay_idle", busy_a, 0);

    // SETTLE=3 loopback sweep
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    caps = 0;
    chk("b0_stim", stim_b, 0);
    for (int i = 1; i <= 11; i++) begin
      step();
      if (cv_b) caps++;
      chk("b_stim", stim_b, i / 3);
      chk("b_cv", cv_b, (i % 3 == 0) ? 1 : 0);
      chk("b_done_lo", done_b, 0);
    end
    step();
    if (cv_b) caps++;
    chk("b12_done", done_b, 1);
    chk("b12_busy", busy_b, 0);
    chk("b_caps", caps, 4);
    chk("b12_ci", ci_b, 3);
    chk("b12_sig", sig_b, SIG_ON ? 32'h3 : 32'h0);
    step();
    chk("b13_idle", busy_b, 0);

    // abort on the 2nd cycle of pattern 2
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    for (int i = 1; i <= 7; i++) step();
    chk("x_pre_stim", stim_b, 2);
    abort_b = 1'b1;
    step();
    abort_b = 1'b0;
    chk("x_busy", busy_b, 0);
    chk("x_stim", stim_b, 0);
    chk("x_sv", sv_b, 0);
    chk("x_cv", cv_b, 0);
    chk("x_ci_hold", ci_b, 1);
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done_b || cv_b || busy_b) bad = 1'b1;
    end
    chk("x_quiet", bad, 0);

    // IN_W=1 inverted response
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    chk("c0_stim", stim_c, 0);
    step();
    chk("c1_cv", cv_c, 1);
    chk("c1_ci", ci_c, 0);
    chk("c1_cd", cd_c, 1);
    chk("c1_stim", stim_c, 1);
    step();
    chk("c2_done", done_c, 1);
    chk("c2_ci", ci_c, 1);
    chk("c2_cd", cd_c, 0);
    chk("c2_stim", stim_c, 0);
    chk("c2_sig", sig_c, SIG_ON ? 32'h2 : 32'h0);
    step();
    chk("c3_busy", busy_c, 0);
    chk("c3_stim", stim_c, 0);
    chk("c3_cv", cv_c, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
